// File: rtl/pipeline_stall_controller_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: state
// encodings, the x0 register constant and the load-use hazard rule.
package pipeline_stall_controller_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RUN      = 2'd1,
    S_MEM_WAIT = 2'd2,
    S_HALT     = 2'd3
  } state_t;

  localparam logic [4:0] REG_X0 = 5'd0;

  // A load in EX whose destination feeds ID must stall one cycle; x0 is hardwired zero.
  function automatic logic load_use_hazard(
    input logic       memrd,
    input logic [4:0] rd,
    input logic [4:0] rs1,
    input logic [4:0] rs2
  );
    return memrd & (rd != REG_X0) & ((rd == rs1) | (rd == rs2));
  endfunction

endpackage

// File: rtl/pipeline_stall_controller_sat_counter.sv
// Saturating up-counter with enable and asynchronous active-high reset.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  // Count enabled cycles, sticking at the maximum value.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= {W{1'b0}};
    end else if (i_en && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pipeline_stall_controller.sv
// Central stall/flush sequencer for the 5-stage pipeline. Merges load-use
// hazards, taken-branch flush and the data-memory req/ack handshake into one
// set of pipeline enables, with a start gate, a memory-wait watchdog and
// saturating stall/bubble counters. Outputs are combinational from state and
// inputs so a zero-wait ack costs no cycle.
module pipeline_stall_controller
  import pipeline_stall_controller_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             id_ex_memrd_i,
  input  logic [4:0]       id_ex_rd_i,
  input  logic [4:0]       if_id_rs1_i,
  input  logic [4:0]       if_id_rs2_i,
  input  logic             branch_i,
  input  logic             mem_access_i,
  input  logic             mem_ack_i,
  output logic             mem_req_o,
  output logic             pc_write_o,
  output logic             if_id_write_o,
  output logic             if_id_flush_o,
  output logic             id_ex_noop_o,
  output logic             freeze_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] bubble_cnt_o
);

  localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  state_t            r_state;
  state_t            w_next_state;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_timeout;
  logic              w_load_use;
  logic              w_wait_inc;
  logic              w_set_timeout;
  logic              w_bubble_en;

  assign w_load_use = load_use_hazard(id_ex_memrd_i, id_ex_rd_i, if_id_rs1_i, if_id_rs2_i);

  // State register; reset returns to IDLE, which drops mem_req_o at once.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Consecutive MEM_WAIT cycles without ack; cleared whenever MEM_WAIT is left.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wait_cnt <= {WAIT_W{1'b0}};
    end else if (w_wait_inc) begin
      r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
    end else begin
      r_wait_cnt <= {WAIT_W{1'b0}};
    end
  end

  // Sticky watchdog flag, only cleared by reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_timeout <= 1'b0;
    end else if (w_set_timeout) begin
      r_timeout <= 1'b1;
    end else begin
      r_timeout <= r_timeout;
    end
  end

  // Next state and pipeline enables: freeze beats load-use beats branch.
  always_comb begin
    w_next_state  = r_state;
    mem_req_o     = 1'b0;
    pc_write_o    = 1'b0;
    if_id_write_o = 1'b0;
    if_id_flush_o = 1'b0;
    id_ex_noop_o  = 1'b0;
    freeze_o      = 1'b0;
    w_wait_inc    = 1'b0;
    w_set_timeout = 1'b0;
    w_bubble_en   = 1'b0;
    case (r_state)
      S_IDLE: begin
        id_ex_noop_o = 1'b1;
        if (start_i) begin
          w_next_state = S_RUN;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_RUN, S_MEM_WAIT: begin
        mem_req_o = mem_access_i;
        if (mem_access_i && !mem_ack_i) begin
          freeze_o = 1'b1;
          if ((r_state == S_MEM_WAIT) && (r_wait_cnt == WAIT_W'(MEM_TIMEOUT - 1))) begin
            w_next_state  = S_HALT;
            w_set_timeout = 1'b1;
          end else begin
            w_next_state = S_MEM_WAIT;
            w_wait_inc   = (r_state == S_MEM_WAIT);
          end
        end else begin
          // Ack (or no access) releases the wait; the ack cycle itself is productive.
          w_next_state = S_RUN;
          if (w_load_use) begin
            id_ex_noop_o = 1'b1;
            w_bubble_en  = 1'b1;
          end else if (branch_i) begin
            if_id_flush_o = 1'b1;
            pc_write_o    = 1'b1;
          end else begin
            pc_write_o    = 1'b1;
            if_id_write_o = 1'b1;
          end
        end
      end
      S_HALT: begin
        id_ex_noop_o = 1'b1;
        freeze_o     = 1'b1;
        w_next_state = S_HALT;
      end
      default: begin
        id_ex_noop_o = 1'b1;
        w_next_state = S_IDLE;
      end
    endcase
  end

  assign timeout_o = r_timeout;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .i_clk (clk_i),
    .i_rst (rst_i),
    .i_en  (freeze_o),
    .o_cnt (stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .i_clk (clk_i),
    .i_rst (rst_i),
    .i_en  (w_bubble_en),
    .o_cnt (bubble_cnt_o)
  );

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Self-checking bench for pipeline_stall_controller: a behavioural model
// checked every cycle plus directed scenarios with literal expectations.
module tb_pipeline_stall_controller;

  localparam int CNT_W   = 3;
  localparam int TMO     = 4;
  localparam int SAT_MAX = 7;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, memrd, branch, mem_access, mem_ack;
  logic [4:0] rd, rs1, rs2;
  logic       mem_req, pc_write, if_id_write, flush, noop, freeze, timeout;
  logic [CNT_W-1:0] stall_cnt, bubble_cnt;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct packed {
    logic mem_req, pc_write, if_id_write, flush, noop, freeze;
  } outs_t;

  // model state
  bit m_run = 1'b0, m_halt = 1'b0, m_timeout = 1'b0;
  int m_consec = 0, m_stall = 0, m_bubble = 0;

  pipeline_stall_controller #(.CNT_W(CNT_W), .MEM_TIMEOUT(TMO)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .id_ex_memrd_i(memrd), .id_ex_rd_i(rd), .if_id_rs1_i(rs1), .if_id_rs2_i(rs2),
    .branch_i(branch), .mem_access_i(mem_access), .mem_ack_i(mem_ack),
    .mem_req_o(mem_req), .pc_write_o(pc_write), .if_id_write_o(if_id_write),
    .if_id_flush_o(flush), .id_ex_noop_o(noop), .freeze_o(freeze),
    .timeout_o(timeout), .stall_cnt_o(stall_cnt), .bubble_cnt_o(bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic outs_t model_outs();
    outs_t o;
    bit    lu;
    o  = '0;
    lu = memrd && (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
    if (m_halt) begin
      o.noop = 1'b1; o.freeze = 1'b1;
    end else if (!m_run) begin
      o.noop = 1'b1;
    end else begin
      o.mem_req = mem_access;
      if (mem_access && !mem_ack)  o.freeze = 1'b1;
      else if (lu)                 o.noop = 1'b1;
      else if (branch) begin o.flush = 1'b1; o.pc_write = 1'b1; end
      else begin o.pc_write = 1'b1; o.if_id_write = 1'b1; end
    end
    return o;
  endfunction

  // model advance on each clock edge (asynchronous reset)
  always @(posedge clk or posedge rst) begin
    outs_t e;
    if (rst) begin
      m_run = 1'b0; m_halt = 1'b0; m_timeout = 1'b0;
      m_consec = 0; m_stall = 0; m_bubble = 0;
    end else begin
      e = model_outs();
      if (e.freeze && m_stall < SAT_MAX) m_stall++;
      if (m_halt) begin
        m_halt = 1'b1;
      end else if (!m_run) begin
        if (start) m_run = 1'b1;
      end else begin
        if (e.noop && m_bubble < SAT_MAX) m_bubble++;
        if (e.freeze) begin
          m_consec++;
          // first frozen RUN cycle plus TMO wait cycles without ack
          if (m_consec == TMO + 1) begin
            m_halt = 1'b1; m_run = 1'b0; m_timeout = 1'b1;
          end
        end else begin
          m_consec = 0;
        end
      end
    end
  end

  // every-cycle comparison against the model, mid-cycle
  always @(negedge clk) begin
    outs_t e;
    if (!rst) begin
      e = model_outs();
      chk("m_mem_req", mem_req, e.mem_req);
      chk("m_pc_write", pc_write, e.pc_write);
      chk("m_if_id_write", if_id_write, e.if_id_write);
      chk("m_flush", flush, e.flush);
      chk("m_noop", noop, e.noop);
      chk("m_freeze", freeze, e.freeze);
      chk("m_timeout", timeout, m_timeout);
      chk("m_stall_cnt", stall_cnt, m_stall);
      chk("m_bubble_cnt", bubble_cnt, m_bubble);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; memrd = 1'b0; branch = 1'b0;
    mem_access = 1'b0; mem_ack = 1'b0; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
    repeat (2) step();
    chk("rst_stall", stall_cnt, 0);
    chk("rst_bubble", bubble_cnt, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_pc_write", pc_write, 0);
    chk("rst_noop", noop, 1);
    chk("rst_mem_req", mem_req, 0);
    rst = 1'b0;

    // 1: start gate
    for (int i = 0; i < 5; i++) begin
      step(); #2;
      chk("idle_pc_write", pc_write, 0);
      chk("idle_noop", noop, 1);
    end
    step(); start = 1'b1; #2;
    chk("start_cycle_pc_write", pc_write, 0);
    step(); start = 1'b0; #2;
    chk("run_pc_write", pc_write, 1);
    chk("run_if_id_write", if_id_write, 1);

    // 2: load-use bubble, and x0 never stalls
    step(); memrd = 1'b1; rd = 5'd5; rs1 = 5'd5; #2;
    chk("lu_noop", noop, 1);
    chk("lu_pc_write", pc_write, 0);
    step(); memrd = 1'b0; #2;
    chk("lu_bubble_cnt", bubble_cnt, 1);
    chk("lu_after_pc_write", pc_write, 1);
    step(); memrd = 1'b1; rd = 5'd0; rs1 = 5'd0; #2;
    chk("x0_noop", noop, 0);
    chk("x0_pc_write", pc_write, 1);
    step(); memrd = 1'b0; #2;
    chk("x0_bubble_cnt", bubble_cnt, 1);

    // 3: memory access acked after 3 cycles
    step(); mem_access = 1'b1; mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("mw_freeze", freeze, 1);
      chk("mw_mem_req", mem_req, 1);
      step();
    end
    mem_ack = 1'b1; #2;
    chk("ack_freeze", freeze, 0);
    chk("ack_mem_req", mem_req, 1);
    step(); mem_access = 1'b0; mem_ack = 1'b0; #2;
    chk("mw_stall_cnt", stall_cnt, 3);

    // 4: branch suppressed by load-use, then taken
    step(); branch = 1'b1; memrd = 1'b1; rd = 5'd7; rs1 = 5'd1; rs2 = 5'd7; #2;
    chk("br_lu_flush", flush, 0);
    chk("br_lu_noop", noop, 1);
    step(); memrd = 1'b0; #2;
    chk("br_flush", flush, 1);
    chk("br_pc_write", pc_write, 1);
    step(); branch = 1'b0; #2;
    chk("br_bubble_cnt", bubble_cnt, 2);

    // bubble counter saturation: 6 more bubbles from 2 saturate at 7
    step(); memrd = 1'b1;
    repeat (5) step();
    step(); memrd = 1'b0; #2;
    chk("bubble_sat", bubble_cnt, 7);

    // 5: watchdog, no ack
    step(); mem_access = 1'b1; mem_ack = 1'b0;
    repeat (5) step();
    #2;
    chk("halt_timeout", timeout, 1);
    chk("halt_mem_req", mem_req, 0);
    chk("halt_freeze", freeze, 1);
    chk("halt_pc_write", pc_write, 0);
    chk("stall_sat", stall_cnt, 7);
    repeat (3) step();
    mem_ack = 1'b1; #2;
    chk("halt_sticky_timeout", timeout, 1);
    chk("halt_sticky_pc_write", pc_write, 0);

    // 6: reset during MEM_WAIT, late ack ignored
    step(); rst = 1'b1; mem_access = 1'b0; mem_ack = 1'b0;
    step(); rst = 1'b0;
    step(); start = 1'b1;
    step(); start = 1'b0; mem_access = 1'b1;
    step(); #2;
    chk("w6_mem_req", mem_req, 1);
    chk("w6_stall_cnt", stall_cnt, 1);
    rst = 1'b1; #1;
    chk("rst_mid_mem_req", mem_req, 0);
    chk("rst_mid_stall", stall_cnt, 0);
    chk("rst_mid_bubble", bubble_cnt, 0);
    chk("rst_mid_timeout", timeout, 0);
    mem_ack = 1'b1;
    step(); rst = 1'b0; #2;
    chk("late_ack_mem_req", mem_req, 0);
    chk("late_ack_pc_write", pc_write, 0);
    step(); mem_access = 1'b0; mem_ack = 1'b0; start = 1'b1;
    step(); start = 1'b0; #2;
    chk("restart_pc_write", pc_write, 1);
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
